rega_timer_ctrl: RTL

Sequencer for the irrigation watering timer. It captures the BCD MM:SS preset produced by the preset generator and counts it down to 00:00 on a 1 Hz tick. It drives the valve for the duration and reports completion or fault to the top-level controller. It sits between the preset generator, the system tick divider and the valve/display outputs.

---
 rtl/rega_timer_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/rega_timer_ctrl.sv
// Irrigation watering timer sequencer: loads a BCD MM:SS preset, counts it down
// on the 1 Hz tick while driving the valve, and reports completion or fault.
module rega_timer_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       abort,
    input  logic       error,
    input  logic [3:0] preset_us,
    input  logic [3:0] preset_ds,
    input  logic [3:0] preset_um,
    input  logic [3:0] preset_dm,
    output logic [3:0] cnt_us,
    output logic [3:0] cnt_ds,
    output logic [3:0] cnt_um,
    output logic [3:0] cnt_dm,
    output logic       valve,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_next_s;
    logic [15:0] cnt_dec_s;
    logic [15:0] preset_s;

    function automatic logic preset_valid(input logic [15:0] p);
        return (p[3:0] <= 4'd9) && (p[7:4] <= 4'd5) &&
               (p[11:8] <= 4'd9) && (p[15:12] <= 4'd5);
    endfunction

    assign preset_s = {preset_dm, preset_um, preset_ds, preset_us};

    // BCD decrement with borrow chain us -> ds -> um -> dm.
    always_comb begin
        cnt_dec_s = cnt_r;
        if (cnt_r[3:0] != 4'd0) begin
            cnt_dec_s[3:0] = cnt_r[3:0] - 4'd1;
        end else begin
            cnt_dec_s[3:0] = 4'd9;
            if (cnt_r[7:4] != 4'd0) begin
                cnt_dec_s[7:4] = cnt_r[7:4] - 4'd1;
            end else begin
                cnt_dec_s[7:4] = 4'd5;
                if (cnt_r[11:8] != 4'd0) begin
                    cnt_dec_s[11:8] = cnt_r[11:8] - 4'd1;
                end else begin
                    cnt_dec_s[11:8]  = 4'd9;
                    cnt_dec_s[15:12] = cnt_r[15:12] - 4'd1;
                end
            end
        end
    end

    // Next-state and next-count selection; error outranks abort outranks start/tick.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (error) begin
                    state_next_s = ST_FAULT;
                    cnt_next_s   = 16'h0000;
                end else if (start && !abort) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (error || (!abort && !preset_valid(preset_s))) begin
                    state_next_s = ST_FAULT;
                    cnt_next_s   = 16'h0000;
                end else if (abort) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = 16'h0000;
                end else if (preset_s == 16'h0000) begin
                    state_next_s = ST_DONE;
                    cnt_next_s   = 16'h0000;
                end else begin
                    state_next_s = ST_RUN;
                    cnt_next_s   = preset_s;
                end
            end
            ST_RUN: begin
                if (error) begin
                    state_next_s = ST_FAULT;
                    cnt_next_s   = 16'h0000;
                end else if (abort) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = 16'h0000;
                end else if (tick) begin
                    cnt_next_s   = cnt_dec_s;
                    state_next_s = (cnt_dec_s == 16'h0000) ? ST_DONE : ST_RUN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                cnt_next_s   = 16'h0000;
                state_next_s = error ? ST_FAULT : ST_IDLE;
            end
            ST_FAULT: begin
                // Leaving needs start low as well, so a stuck start cannot re-arm.
                cnt_next_s   = 16'h0000;
                state_next_s = (!error && !start) ? ST_IDLE : ST_FAULT;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 16'h0000;
            end
        endcase
    end

    // State and count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'h0000;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    assign cnt_us = cnt_r[3:0];
    assign cnt_ds = cnt_r[7:4];
    assign cnt_um = cnt_r[11:8];
    assign cnt_dm = cnt_r[15:12];
    assign valve  = (state_r == ST_RUN);
    assign busy   = (state_r == ST_LOAD) || (state_r == ST_RUN);
    assign done   = (state_r == ST_DONE);
    assign fault  = (state_r == ST_FAULT);

endmodule
